// File: rtl/mem_wait_ctrl_pkg.sv
// Shared FSM encoding, read-wait default and counter sizing helpers for mem_wait_ctrl.
package mem_wait_ctrl_pkg;

    localparam int READ_WAIT_DEF = 3;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RWAIT = 2'd1;
    localparam logic [1:0] ST_WRITE = 2'd2;
    localparam logic [1:0] ST_DRAIN = 2'd3;

    typedef enum logic [1:0] {
        IDLE  = ST_IDLE,
        RWAIT = ST_RWAIT,
        WRITE = ST_WRITE,
        DRAIN = ST_DRAIN
    } state_e;

    // A zero wait still needs one cycle for the memory to present data.
    function automatic int eff_wait(input int rw);
        return (rw < 1) ? 1 : rw;
    endfunction

    function automatic int cnt_width(input int rw);
        return (rw < 1) ? 1 : $clog2(rw + 1);
    endfunction

endpackage

// File: rtl/mem_wait_cnt.sv
// Down-counter for the RWAIT phase: load, decrement, saturate at zero.
module mem_wait_cnt #(
    parameter int CNT_W = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             dec,
    output logic             zero
);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (dec && (cnt != '0)) begin
            cnt <= cnt - CNT_W'(1);
        end
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/mem_wait_ctrl.sv
// Wait-state memory controller: one outstanding CPU access, fixed read wait.
// Optional posted-write buffer enabled by defining MEM_WAIT_CTRL_WBUF_EN.
module mem_wait_ctrl
    import mem_wait_ctrl_pkg::*;
#(
    parameter int READ_WAIT = READ_WAIT_DEF,
    parameter int ADDR_W    = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [31:0]       cpu_wdata,
    output logic              cpu_ready,
    output logic [31:0]       cpu_rdata,
    output logic              cpu_rvalid,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_address,
    output logic [31:0]       mem_write_data,
    input  logic [31:0]       mem_read_data
);

    localparam int               RW_EFF   = eff_wait(READ_WAIT);
    localparam int               CNT_W    = cnt_width(READ_WAIT);
    localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(RW_EFF - 1);

    state_e state;
    logic   ready_en;
    logic   accept;
    logic   cnt_zero;

    function automatic logic [ADDR_W-1:0] align_word(input logic [ADDR_W-1:0] a);
        return a & ~{{(ADDR_W-2){1'b0}}, 2'b11};
    endfunction

    // ready_en keeps cpu_ready low until the first edge after reset release.
    assign cpu_ready = ready_en && (state == IDLE);
    assign accept    = cpu_req && cpu_ready;
    assign mem_read  = (state == RWAIT);

    mem_wait_cnt #(
        .CNT_W (CNT_W)
    ) u_cnt (
        .clk      (clk),
        .reset    (reset),
        .load     (accept && !cpu_we),
        .load_val (LOAD_VAL),
        .dec      ((state == RWAIT) && !cnt_zero),
        .zero     (cnt_zero)
    );

`ifdef MEM_WAIT_CTRL_WBUF_EN
    logic wbuf_vld;

    assign mem_write = (state == DRAIN) && wbuf_vld;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wbuf_vld <= 1'b0;
        end else if (accept && cpu_we) begin
            wbuf_vld <= 1'b1;
        end else if (state == DRAIN) begin
            wbuf_vld <= 1'b0;
        end
    end
`else
    assign mem_write = (state == WRITE);
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state          <= IDLE;
            ready_en       <= 1'b0;
            cpu_rvalid     <= 1'b0;
            cpu_rdata      <= '0;
            mem_address    <= '0;
            mem_write_data <= '0;
        end else begin
            ready_en   <= 1'b1;
            cpu_rvalid <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        mem_address <= align_word(cpu_addr);
                        if (cpu_we) begin
                            mem_write_data <= cpu_wdata;
`ifdef MEM_WAIT_CTRL_WBUF_EN
                            state          <= DRAIN;
`else
                            state          <= WRITE;
`endif
                        end else begin
                            state <= RWAIT;
                        end
                    end
                end
                // Data has settled by the last wait edge; capture and release.
                RWAIT: begin
                    if (cnt_zero) begin
                        cpu_rdata  <= mem_read_data;
                        cpu_rvalid <= 1'b1;
                        state      <= IDLE;
                    end
                end
                WRITE, DRAIN: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_wait_ctrl.sv
// Self-checking bench for mem_wait_ctrl: directed vectors, corner sequences, randomized traffic.
module tb_mem_wait_ctrl;

    localparam int RW = 3;

    logic        clk = 1'b0;
    logic        reset;
    logic        cpu_req, cpu_we;
    logic [31:0] cpu_addr, cpu_wdata;

    logic        cpu_ready, cpu_rvalid, mem_read, mem_write;
    logic [31:0] cpu_rdata, mem_address, mem_write_data, mem_read_data;

    logic        z_ready, z_rvalid, z_mrd, z_mwr;
    logic [31:0] z_rdata, z_maddr, z_mwd, z_mrdata;
    logic        f_ready, f_rvalid, f_mrd, f_mwr;
    logic [31:0] f_rdata, f_maddr, f_mwd, f_mrdata;

    logic [31:0] mem  [0:255];
    logic [31:0] mmem [0:255];

    int n_cmp  = 0;
    int n_fail = 0;
    int e      = 0;
    logic [31:0] last_rd;

    always #5 clk = ~clk;

    assign mem_read_data = mem[mem_address[9:2]];
    assign z_mrdata      = z_maddr ^ 32'h5A5A_0000;
    assign f_mrdata      = f_maddr ^ 32'h5A5A_0000;

    always @(posedge clk) begin
        if (mem_write) mem[mem_address[9:2]] <= mem_write_data;
    end

    mem_wait_ctrl #(.READ_WAIT(RW), .ADDR_W(32)) dut (
        .clk(clk), .reset(reset), .cpu_req(cpu_req), .cpu_we(cpu_we),
        .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_ready(cpu_ready),
        .cpu_rdata(cpu_rdata), .cpu_rvalid(cpu_rvalid), .mem_read(mem_read),
        .mem_write(mem_write), .mem_address(mem_address),
        .mem_write_data(mem_write_data), .mem_read_data(mem_read_data));

    mem_wait_ctrl #(.READ_WAIT(0), .ADDR_W(32)) dut_w0 (
        .clk(clk), .reset(reset), .cpu_req(cpu_req), .cpu_we(cpu_we),
        .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_ready(z_ready),
        .cpu_rdata(z_rdata), .cpu_rvalid(z_rvalid), .mem_read(z_mrd),
        .mem_write(z_mwr), .mem_address(z_maddr),
        .mem_write_data(z_mwd), .mem_read_data(z_mrdata));

    mem_wait_ctrl #(.READ_WAIT(5), .ADDR_W(32)) dut_w5 (
        .clk(clk), .reset(reset), .cpu_req(cpu_req), .cpu_we(cpu_we),
        .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_ready(f_ready),
        .cpu_rdata(f_rdata), .cpu_rvalid(f_rvalid), .mem_read(f_mrd),
        .mem_write(f_mwr), .mem_address(f_maddr),
        .mem_write_data(f_mwd), .mem_read_data(f_mrdata));

    typedef struct {
        string       name;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic [31:0] exp_maddr;
    } vec_t;

    vec_t vt [6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (edge %0d)", name, act, exp, e);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b, expected %b (edge %0d)", name, act, exp, e);
        end
    endtask

    task automatic step();
        @(posedge clk);
        e++;
        #1;
    endtask

    task automatic wait_ready(input string name);
        int w = 0;
        while (!cpu_ready && w < 20) begin
            step();
            w++;
        end
        chk1({name, " ready before request"}, cpu_ready, 1'b1);
    endtask

    task automatic do_txn(input vec_t v);
        int n_rd = 0;
        int n_wr = 0;
        int n_rv = 0;
        logic [31:0] rd = '0;
        wait_ready(v.name);
        cpu_req = 1'b1; cpu_we = v.we; cpu_addr = v.addr; cpu_wdata = v.wdata;
        step();
        cpu_req = 1'b0;
        for (int k = 0; k < 10; k++) begin
            chk1({v.name, " rd/wr exclusive"}, mem_read && mem_write, 1'b0);
            if (mem_read) begin
                n_rd++;
                chk({v.name, " mem_address on read"}, mem_address, v.exp_maddr);
            end
            if (mem_write) begin
                n_wr++;
                chk({v.name, " mem_address on write"}, mem_address, v.exp_maddr);
                chk({v.name, " mem_write_data"}, mem_write_data, v.wdata);
            end
            if (cpu_rvalid) begin
                n_rv++;
                rd = cpu_rdata;
            end
            step();
        end
        if (v.we) begin
            chk({v.name, " mem_write cycles"}, 32'(n_wr), 32'd1);
            chk({v.name, " mem_read cycles"}, 32'(n_rd), 32'd0);
            chk({v.name, " rvalid pulses"}, 32'(n_rv), 32'd0);
        end else begin
            chk({v.name, " mem_read cycles"}, 32'(n_rd), 32'(RW));
            chk({v.name, " mem_write cycles"}, 32'(n_wr), 32'd0);
            chk({v.name, " rvalid pulses"}, 32'(n_rv), 32'd1);
            chk({v.name, " rdata at rvalid"}, rd, v.exp_rdata);
            chk({v.name, " rdata held"}, cpu_rdata, v.exp_rdata);
            last_rd = v.exp_rdata;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat_m, lat_z, lat_f, n_rd, n_rv, n_wr;
        logic [31:0] rd;
        logic exp_rdy, exp_mr, exp_mw;
        int free_at, rd_start, rd_done, wr_at, nacc;
        logic [31:0] rd_addr, wr_addr, wr_data, rd_pend;
        logic [7:0] idx;

        vt[0] = '{"rd C8",    1'b0, 32'h0000_00C8, 32'h0,          32'hDEAD_BEEF, 32'h0000_00C8};
        vt[1] = '{"wr CA",    1'b1, 32'h0000_00CA, 32'h1234_5678,  32'h0,         32'h0000_00C8};
        vt[2] = '{"rd C8 b",  1'b0, 32'h0000_00C8, 32'h0,          32'h1234_5678, 32'h0000_00C8};
        vt[3] = '{"wr 3FF",   1'b1, 32'h0000_03FF, 32'hA5A5_A5A5,  32'h0,         32'h0000_03FC};
        vt[4] = '{"rd 0",     1'b0, 32'h0000_0000, 32'h0,          32'h0000_0000, 32'h0000_0000};
        vt[5] = '{"rd 3FD",   1'b0, 32'h0000_03FD, 32'h0,          32'hA5A5_A5A5, 32'h0000_03FC};

        for (int i = 0; i < 256; i++) mem[i] = '0;
        mem[8'h32] = 32'hDEAD_BEEF;
        mem[8'h10] = 32'h0BAD_F00D;
        mem[8'h40] = 32'hBAD0_0100;
        mem[8'h80] = 32'h1111_1111;
        last_rd = '0;

        cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
        reset = 1'b0;
        step(); step();

        chk1("reset cpu_ready", cpu_ready, 1'b0);
        chk1("reset mem_read", mem_read, 1'b0);
        chk1("reset mem_write", mem_write, 1'b0);
        chk1("reset cpu_rvalid", cpu_rvalid, 1'b0);
        chk("reset cpu_rdata", cpu_rdata, 32'h0);
        chk("reset mem_address", mem_address, 32'h0);
        chk("reset mem_write_data", mem_write_data, 32'h0);

        reset = 1'b1;
        #1;
        chk1("ready before first edge after release", cpu_ready, 1'b0);
        step();
        chk1("ready after first edge", cpu_ready, 1'b1);
        chk1("ready w0", z_ready, 1'b1);
        chk1("ready w5", f_ready, 1'b1);

        // Read latency across three READ_WAIT builds issued in lockstep.
        lat_m = -1; lat_z = -1; lat_f = -1;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h0000_0040;
        step();
        cpu_req = 1'b0;
        chk("w0 mem_address", z_maddr, 32'h0000_0040);
        chk("w5 mem_address", f_maddr, 32'h0000_0040);
        for (int k = 0; k < 9; k++) begin
            if (cpu_rvalid && lat_m < 0) lat_m = k;
            if (z_rvalid && lat_z < 0) lat_z = k;
            if (f_rvalid && lat_f < 0) lat_f = k;
            chk1("w0 no write", z_mwr, 1'b0);
            chk1("w5 no write", f_mwr, 1'b0);
            step();
        end
        chk("latency RW=3", 32'(lat_m), 32'd3);
        chk("latency RW=0", 32'(lat_z), 32'd1);
        chk("latency RW=5", 32'(lat_f), 32'd5);
        chk("w0 rdata", z_rdata, 32'h5A5A_0040);
        chk("w5 rdata", f_rdata, 32'h5A5A_0040);
        chk("main rdata 40", cpu_rdata, 32'h0BAD_F00D);
        chk("w0 mem_write_data", z_mwd, 32'h0);
        chk("w5 mem_write_data", f_mwd, 32'h0);
        chk1("w0 mem_read idle", z_mrd, 1'b0);
        chk1("w5 mem_read idle", f_mrd, 1'b0);

        for (int i = 0; i < 6; i++) do_txn(vt[i]);

        // Request held high through RWAIT with another address is ignored.
        wait_ready("held");
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h0000_00C8;
        step();
        cpu_addr = 32'h0000_0100;
        n_rd = 0; n_rv = 0; n_wr = 0; rd = '0;
        for (int k = 0; k < 12; k++) begin
            if (k == RW - 1) cpu_req = 1'b0;
            if (mem_read) begin
                n_rd++;
                chk("held mem_address", mem_address, 32'h0000_00C8);
            end
            if (mem_write) n_wr++;
            if (cpu_rvalid) begin
                n_rv++;
                rd = cpu_rdata;
            end
            step();
        end
        chk("held mem_read cycles", 32'(n_rd), 32'(RW));
        chk("held mem_write cycles", 32'(n_wr), 32'd0);
        chk("held rvalid pulses", 32'(n_rv), 32'd1);
        chk("held rdata", rd, 32'h1234_5678);

        // Reset in the second RWAIT cycle aborts the read.
        wait_ready("abort rd");
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h0000_03FC;
        step();
        cpu_req = 1'b0;
        step();
        chk1("abort precondition mem_read", mem_read, 1'b1);
        reset = 1'b0;
        #1;
        chk1("abort cpu_ready", cpu_ready, 1'b0);
        chk1("abort mem_read", mem_read, 1'b0);
        chk1("abort mem_write", mem_write, 1'b0);
        chk1("abort cpu_rvalid", cpu_rvalid, 1'b0);
        chk("abort cpu_rdata", cpu_rdata, 32'h0);
        chk("abort mem_address", mem_address, 32'h0);
        chk("abort mem_write_data", mem_write_data, 32'h0);
        step(); step();
        reset = 1'b1;
        step();
        chk1("abort ready after release", cpu_ready, 1'b1);
        n_rd = 0; n_rv = 0;
        for (int k = 0; k < 8; k++) begin
            if (mem_read || mem_write) n_rd++;
            if (cpu_rvalid) n_rv++;
            step();
        end
        chk("abort no mem access after", 32'(n_rd), 32'd0);
        chk("abort no rvalid after", 32'(n_rv), 32'd0);

        // Reset while the write strobe is up: memory must never commit it.
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 32'h0000_0200; cpu_wdata = 32'hFFFF_0000;
        step();
        cpu_req = 1'b0;
        reset = 1'b0;
        #1;
        chk1("abort wr mem_write", mem_write, 1'b0);
        step();
        reset = 1'b1;
        step(); step();
        chk("abort wr memory untouched", mem[8'h80], 32'h1111_1111);
        last_rd = '0;

        // Write immediately followed by a read of the same word.
        wait_ready("wr-rd");
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 32'h0000_0124; cpu_wdata = 32'hCAFE_F00D;
        step();
        chk1("wr-rd ready during write cycle", cpu_ready, 1'b0);
        chk1("wr-rd mem_write", mem_write, 1'b1);
        cpu_we = 1'b0;
        step();
        chk1("wr-rd ready after one cycle", cpu_ready, 1'b1);
        step();
        cpu_req = 1'b0;
        n_rv = 0; rd = '0;
        for (int k = 0; k < 10; k++) begin
            if (cpu_rvalid) begin
                n_rv++;
                rd = cpu_rdata;
            end
            step();
        end
        chk("wr-rd rvalid pulses", 32'(n_rv), 32'd1);
        chk("wr-rd rdata", rd, 32'hCAFE_F00D);
        last_rd = 32'hCAFE_F00D;

        // Randomized traffic against a transaction-level timing model.
        for (int i = 0; i < 256; i++) begin
            mem[i]  = $urandom;
            mmem[i] = mem[i];
        end
        free_at = e; rd_start = -1; rd_done = -1; wr_at = -1;
        rd_addr = '0; wr_addr = '0; wr_data = '0; rd_pend = '0;
        for (int c = 0; c < 400; c++) begin
            if (e == rd_done) last_rd = rd_pend;
            exp_rdy = (e >= free_at);
            exp_mr  = (rd_start >= 0) && (e >= rd_start) && (e < rd_done);
            exp_mw  = (e == wr_at);
            chk1("rnd cpu_ready", cpu_ready, exp_rdy);
            chk1("rnd cpu_rvalid", cpu_rvalid, e == rd_done);
            chk1("rnd mem_read", mem_read, exp_mr);
            chk1("rnd mem_write", mem_write, exp_mw);
            chk("rnd cpu_rdata", cpu_rdata, last_rd);
            if (exp_mr) chk("rnd read address", mem_address, rd_addr);
            if (exp_mw) begin
                chk("rnd write address", mem_address, wr_addr);
                chk("rnd write data", mem_write_data, wr_data);
            end
            cpu_req   = ($urandom_range(0, 3) != 0);
            cpu_we    = 1'($urandom_range(0, 1));
            cpu_addr  = 32'($urandom_range(0, 1023));
            cpu_wdata = $urandom;
            if (cpu_req && exp_rdy) begin
                nacc = e + 1;
                idx  = cpu_addr[9:2];
                if (cpu_we) begin
                    wr_at     = nacc;
                    wr_addr   = cpu_addr & 32'hFFFF_FFFC;
                    wr_data   = cpu_wdata;
                    mmem[idx] = cpu_wdata;
                    free_at   = nacc + 1;
                end else begin
                    rd_start = nacc;
                    rd_done  = nacc + RW;
                    rd_addr  = cpu_addr & 32'hFFFF_FFFC;
                    rd_pend  = mmem[idx];
                    free_at  = nacc + RW;
                end
            end
            step();
        end
        cpu_req = 1'b0;
        for (int k = 0; k < 8; k++) step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
